// File: rtl/mem_sram_resp.sv
// Single-port SRAM target for the core's req/gnt/rvalid data-memory protocol.
// Optional: define MEM_SRAM_RESP_ERR_EN to add err_o and flag out-of-range word addresses.
module mem_sram_resp #(
    parameter int DEPTH   = 4096,
    parameter int LATENCY = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_i,
    input  logic        we_i,
    input  logic [3:0]  be_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] data_i,
    output logic        gnt_o,
    output logic        rvalid_o,
    output logic [31:0] data_o
`ifdef MEM_SRAM_RESP_ERR_EN
    ,
    output logic        err_o
`endif
);
    localparam int         AW       = $clog2(DEPTH);
    localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

    typedef enum logic {S_IDLE, S_BUSY} state_t;

    state_t        state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [31:0]   mem [DEPTH];
    logic [AW-1:0] idx;
    logic          accept;
    logic          last;
    logic          in_range;
    logic          we_q;
    logic          oor_q;
    logic [31:0]   rdata_q;
    logic          unused_addr;

    assign idx = addr_i[AW+1:2];

`ifdef MEM_SRAM_RESP_ERR_EN
    assign in_range    = ~|addr_i[31:AW+2];
    assign unused_addr = ^addr_i[1:0];
`else
    assign in_range    = 1'b1;
    assign unused_addr = ^{addr_i[31:AW+2], addr_i[1:0]};
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // The rvalid cycle still holds gnt_o high but never accepts a new request.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        gnt_o   = 1'b0;
        accept  = 1'b0;
        last    = 1'b0;
        case (state_q)
            S_IDLE: begin
                gnt_o = req_i;
                if (req_i) begin
                    accept  = 1'b1;
                    cnt_d   = CNT_LOAD;
                    state_d = S_BUSY;
                end
            end
            S_BUSY: begin
                gnt_o = 1'b1;
                if (cnt_q == 4'd0) begin
                    last    = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we_q  <= 1'b0;
            oor_q <= 1'b0;
        end else if (accept) begin
            we_q  <= we_i;
            oor_q <= ~in_range;
        end
    end

    // Writes commit at the grant edge; reads sample the array at the same edge, which
    // stays stable while busy because only the idle state can write.
    always_ff @(posedge clk) begin
        if (accept && rst_n) begin
            if (we_i && in_range) begin
                for (int n = 0; n < 4; n++) begin
                    if (be_i[n]) mem[idx][8*n +: 8] <= data_i[8*n +: 8];
                end
            end
            rdata_q <= mem[idx];
        end
    end

    assign rvalid_o = last;
    assign data_o   = (last && !we_q && !oor_q) ? rdata_q : 32'h0;

`ifdef MEM_SRAM_RESP_ERR_EN
    assign err_o = last && oor_q;
`endif

endmodule

// File: tb/tb_mem_sram_resp.sv
// Self-checking bench for mem_sram_resp: two instances (LATENCY=1/DEPTH=4096 and
// LATENCY=3/DEPTH=16) checked against a word-array reference model.
module tb_mem_sram_resp;
    localparam int DEPTH_A = 4096;
    localparam int LAT_A   = 1;
    localparam int DEPTH_B = 16;
    localparam int LAT_B   = 3;
`ifdef MEM_SRAM_RESP_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req = 1'b0;
    logic        we = 1'b0;
    logic [3:0]  be = 4'h0;
    logic [31:0] addr = 32'h0;
    logic [31:0] wdata = 32'h0;
    int          sel = 0;

    logic        req_a, req_b;
    logic        gnt_a, gnt_b, rvalid_a, rvalid_b;
    logic [31:0] data_a, data_b;
    logic        gnt, rvalid;
    logic [31:0] rdata;
`ifdef MEM_SRAM_RESP_ERR_EN
    logic        err_a, err_b, err;
`endif

    logic [31:0] ref_a [DEPTH_A];
    logic [31:0] ref_b [DEPTH_B];
    int          vectors = 0;
    int          miscompares = 0;

    always #5 clk = ~clk;

    assign req_a  = req && (sel == 0);
    assign req_b  = req && (sel == 1);
    assign gnt    = (sel == 0) ? gnt_a    : gnt_b;
    assign rvalid = (sel == 0) ? rvalid_a : rvalid_b;
    assign rdata  = (sel == 0) ? data_a   : data_b;
`ifdef MEM_SRAM_RESP_ERR_EN
    assign err    = (sel == 0) ? err_a    : err_b;
`endif

    mem_sram_resp #(.DEPTH(DEPTH_A), .LATENCY(LAT_A)) dut_a (
        .clk(clk), .rst_n(rst_n), .req_i(req_a), .we_i(we), .be_i(be),
        .addr_i(addr), .data_i(wdata), .gnt_o(gnt_a), .rvalid_o(rvalid_a),
        .data_o(data_a)
`ifdef MEM_SRAM_RESP_ERR_EN
        , .err_o(err_a)
`endif
    );

    mem_sram_resp #(.DEPTH(DEPTH_B), .LATENCY(LAT_B)) dut_b (
        .clk(clk), .rst_n(rst_n), .req_i(req_b), .we_i(we), .be_i(be),
        .addr_i(addr), .data_i(wdata), .gnt_o(gnt_b), .rvalid_o(rvalid_b),
        .data_o(data_b)
`ifdef MEM_SRAM_RESP_ERR_EN
        , .err_o(err_b)
`endif
    );

    // One complete access on instance s, starting at the next negedge; consecutive
    // calls therefore issue the next request in the cycle right after rvalid.
    task automatic access(input int s, input logic w, input logic [3:0] b,
                          input logic [31:0] a, input logic [31:0] d, input bit hold);
        int          lat;
        int          idx;
        bit          oor;
        logic [31:0] cur;
        logic [31:0] exp_data;
        lat = (s == 0) ? LAT_A : LAT_B;
        if (s == 0) begin
            idx = int'((a >> 2) % DEPTH_A);
            oor = ERR_EN && ((a >> 2) >= DEPTH_A);
            cur = ref_a[idx];
        end else begin
            idx = int'((a >> 2) % DEPTH_B);
            oor = ERR_EN && ((a >> 2) >= DEPTH_B);
            cur = ref_b[idx];
        end
        exp_data = (w || oor) ? 32'h0 : cur;
        if (w && !oor) begin
            for (int n = 0; n < 4; n++) if (b[n]) cur[8*n +: 8] = d[8*n +: 8];
            if (s == 0) ref_a[idx] = cur;
            else        ref_b[idx] = cur;
        end

        @(negedge clk);
        sel = s; req = 1'b1; we = w; be = b; addr = a; wdata = d;
        #1;
        vectors++;
        if (gnt !== 1'b1 || rvalid !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL grant_cycle dut%0d addr=%h: gnt=%b rvalid=%b, required gnt=1 rvalid=0",
                     s, a, gnt, rvalid);
        end
        @(posedge clk);
        #1;
        if (!hold) begin
            req = 1'b0; we = ~w; be = 4'($urandom); addr = $urandom; wdata = $urandom;
        end
        for (int c = 1; c <= lat; c++) begin
            @(negedge clk);
            vectors++;
            if (gnt !== 1'b1 || rvalid !== (c == lat)) begin
                miscompares++;
                $display("[TB] FAIL busy_timing dut%0d cycle %0d: gnt=%b rvalid=%b, required gnt=1 rvalid=%b",
                         s, c, gnt, rvalid, (c == lat));
            end
            vectors++;
            if (c == lat) begin
                if (rdata !== exp_data) begin
                    miscompares++;
                    $display("[TB] FAIL rdata dut%0d addr=%h we=%b: got %h, required %h",
                             s, a, w, rdata, exp_data);
                end
`ifdef MEM_SRAM_RESP_ERR_EN
                vectors++;
                if (err !== oor) begin
                    miscompares++;
                    $display("[TB] FAIL err dut%0d addr=%h: got %b, required %b", s, a, err, oor);
                end
`endif
            end else if (rdata !== 32'h0) begin
                miscompares++;
                $display("[TB] FAIL busy_data dut%0d cycle %0d: got %h, required 0", s, c, rdata);
            end
        end
        req = 1'b0;
    endtask

    task automatic check_idle(input string name);
        @(negedge clk);
        vectors++;
        if ({gnt_a, gnt_b, rvalid_a, rvalid_b} !== 4'b0 || data_a !== 32'h0 || data_b !== 32'h0) begin
            miscompares++;
            $display("[TB] FAIL %s: gnt=%b%b rvalid=%b%b data=%h/%h, required all 0",
                     name, gnt_a, gnt_b, rvalid_a, rvalid_b, data_a, data_b);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        vectors++;
        if ({gnt_a, gnt_b, rvalid_a, rvalid_b} !== 4'b0 || data_a !== 32'h0 || data_b !== 32'h0) begin
            miscompares++;
            $display("[TB] FAIL reset_outputs: gnt=%b%b rvalid=%b%b data=%h/%h, required all 0",
                     gnt_a, gnt_b, rvalid_a, rvalid_b, data_a, data_b);
        end
`ifdef MEM_SRAM_RESP_ERR_EN
        vectors++;
        if (err_a !== 1'b0 || err_b !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL reset_err: got %b%b, required 00", err_a, err_b);
        end
`endif
        rst_n = 1'b1;
    endtask

    task automatic test_write_read();
        access(0, 1'b1, 4'hF, 32'h10, 32'hDEADBEEF, 1'b0);
        access(0, 1'b0, 4'hF, 32'h10, $urandom, 1'b0);
    endtask

    task automatic test_byte_write();
        access(0, 1'b1, 4'hF, 32'h20, 32'h11223344, 1'b0);
        access(0, 1'b1, 4'b0100, 32'h20, 32'h00AA0000, 1'b0);
        access(0, 1'b0, 4'h0, 32'h20, $urandom, 1'b0);
        access(0, 1'b1, 4'h0, 32'h20, 32'hFFFFFFFF, 1'b0);
        access(0, 1'b0, 4'hF, 32'h22, $urandom, 1'b0);
    endtask

    task automatic test_latency3();
        access(1, 1'b1, 4'hF, 32'h20, 32'hA5A5_5A5A, 1'b1);
        check_idle("no_regrant_after_write");
        access(1, 1'b0, 4'hF, 32'h20, $urandom, 1'b1);
        check_idle("no_regrant_after_read");
    endtask

    task automatic test_back_to_back();
        access(0, 1'b1, 4'hF, 32'h10, 32'h00000055, 1'b0);
        access(0, 1'b0, 4'hF, 32'h10, $urandom, 1'b0);
        access(1, 1'b1, 4'hF, 32'h10, 32'h00000066, 1'b0);
        access(1, 1'b0, 4'hF, 32'h10, $urandom, 1'b0);
        check_idle("idle_after_back_to_back");
    endtask

    task automatic test_reset_midop();
        logic [31:0] val;
        val = $urandom;
        ref_b[2] = val;
        @(negedge clk);
        sel = 1; req = 1'b1; we = 1'b1; be = 4'hF; addr = 32'h8; wdata = val;
        @(posedge clk);
        #1 req = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        vectors++;
        if (gnt_b !== 1'b0 || rvalid_b !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL reset_midop_async: gnt=%b rvalid=%b, required 0 0", gnt_b, rvalid_b);
        end
        for (int c = 0; c <= LAT_B; c++) begin
            @(negedge clk);
            vectors++;
            if (gnt_b !== 1'b0 || rvalid_b !== 1'b0) begin
                miscompares++;
                $display("[TB] FAIL reset_midop_hold cycle %0d: gnt=%b rvalid=%b, required 0 0",
                         c, gnt_b, rvalid_b);
            end
        end
        rst_n = 1'b1;
        access(1, 1'b0, 4'hF, 32'h8, $urandom, 1'b0);
    endtask

    task automatic test_addr_range();
        access(1, 1'b1, 4'hF, 32'h0, 32'hCAFEF00D, 1'b0);
        access(1, 1'b1, 4'hF, 32'h40, 32'hFFFFFFFF, 1'b0);
        access(1, 1'b0, 4'hF, 32'h40, $urandom, 1'b0);
        access(1, 1'b0, 4'hF, 32'h0, $urandom, 1'b0);
        access(0, 1'b0, 4'hF, 32'h8000_0010, $urandom, 1'b0);
    endtask

    task automatic test_random();
        logic [31:0] r;
        for (int i = 0; i < 16; i++) begin
            access(0, 1'b1, 4'hF, 32'(i * 4), $urandom, 1'b0);
            access(1, 1'b1, 4'hF, 32'(i * 4), $urandom, 1'b0);
        end
        for (int i = 0; i < 80; i++) begin
            r = $urandom;
            access(int'($urandom_range(1, 0)), 1'($urandom), 4'($urandom),
                   $urandom_range(1, 0) ? (r & 32'hFFFF_C03F) : (r & 32'h0000_003F),
                   $urandom, 1'($urandom));
        end
        check_idle("idle_after_random");
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_byte_write();
        test_latency3();
        test_back_to_back();
        test_reset_midop();
        test_addr_range();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
